mem_port_arbiter: RTL and testbench

//  Shares the single unified instruction/data memory between the multicycle ARM

---
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module      : mem_port_arbiter                                           |
// | Description : Shares one unified memory port between the CPU core and a  |
// |               DMA/loader master. Parked on the CPU, with bounded         |
// |               round-robin hand-over and an optional DMA burst lock.      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MAXHOLD = 4
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_adr,
    input  logic [DW-1:0] cpu_wd,
    output logic [DW-1:0] cpu_rd,
    output logic          cpu_gnt,
    output logic          cpu_stall,

    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_adr,
    input  logic [DW-1:0] dma_wd,
    input  logic          dma_lock,
    output logic [DW-1:0] dma_rd,
    output logic          dma_gnt,

    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    localparam int             HCW      = $clog2(MAXHOLD + 1);
    localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAXHOLD);

    typedef enum logic [0:0] {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

    owner_e         state_q;
    owner_e         state_d;
    logic [HCW-1:0] hold_cnt_q;
    logic [HCW-1:0] hold_cnt_d;

    logic           hold_full;
    logic           other_req;
    logic           owner_req;
    logic           owner_we;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= OWN_CPU;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        hold_full  = (hold_cnt_q == HOLD_MAX);
        other_req  = 1'b0;

        case (state_q)
            OWN_CPU: begin
                other_req = dma_req;
                if (dma_req && (!cpu_req || hold_full)) begin
                    state_d = OWN_DMA;
                end
            end
            OWN_DMA: begin
                other_req = cpu_req;
                if (!dma_req || (cpu_req && hold_full && !dma_lock)) begin
                    state_d = OWN_CPU;
                end
            end
            default: begin
                state_d = OWN_CPU;
            end
        endcase

        // Counter only runs while someone is actually waiting; it saturates so a locked burst never wraps.
        if ((state_d != state_q) || !other_req) begin
            hold_cnt_d = '0;
        end else if (!hold_full) begin
            hold_cnt_d = hold_cnt_q + HCW'(1);
        end
    end

    always_comb begin
        cpu_gnt = (state_q == OWN_CPU);
        dma_gnt = (state_q == OWN_DMA);

        if (state_q == OWN_DMA) begin
            mem_adr   = dma_adr;
            mem_wd    = dma_wd;
            owner_req = dma_req;
            owner_we  = dma_we;
        end else begin
            mem_adr   = cpu_adr;
            mem_wd    = cpu_wd;
            owner_req = cpu_req;
            owner_we  = cpu_we;
        end

        // Gating with reset keeps a write from landing while reset is held, even though the CPU is parked as owner.
        mem_we    = reset & owner_req & owner_we;
        cpu_stall = cpu_req & ~cpu_gnt;
        cpu_rd    = mem_rd;
        dma_rd    = mem_rd;
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_mem_port_arbiter                                        |
// | Description : Directed, table-driven bench for mem_port_arbiter with a   |
// |               small word-addressed RAM behind the memory port.           |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          cpu_req, cpu_we, cpu_gnt, cpu_stall;
    logic [AW-1:0] cpu_adr;
    logic [DW-1:0] cpu_wd, cpu_rd;
    logic          dma_req, dma_we, dma_lock, dma_gnt;
    logic [AW-1:0] dma_adr;
    logic [DW-1:0] dma_wd, dma_rd;
    logic          mem_we;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wd, mem_rd;

    logic [31:0] ram [0:63];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        creq, cwe, dreq, dwe, lock;
        logic        cgnt, dgnt, stall, mwe;
        logic        chk_rd;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl[$];

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAXHOLD(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_adr   (cpu_adr),
        .cpu_wd    (cpu_wd),
        .cpu_rd    (cpu_rd),
        .cpu_gnt   (cpu_gnt),
        .cpu_stall (cpu_stall),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_adr   (dma_adr),
        .dma_wd    (dma_wd),
        .dma_lock  (dma_lock),
        .dma_rd    (dma_rd),
        .dma_gnt   (dma_gnt),
        .mem_we    (mem_we),
        .mem_adr   (mem_adr),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = ram[mem_adr[7:2]];

    always @(posedge clk) begin
        if (mem_we) ram[mem_adr[7:2]] <= mem_wd;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic creq, cwe, dreq, dwe, lock,
                       input logic cgnt, dgnt, stall, mwe,
                       input logic chk_rd, input logic [31:0] rd);
        vec_t v;
        v.creq = creq; v.cwe = cwe; v.dreq = dreq; v.dwe = dwe; v.lock = lock;
        v.cgnt = cgnt; v.dgnt = dgnt; v.stall = stall; v.mwe = mwe;
        v.chk_rd = chk_rd; v.rd = rd;
        tbl.push_back(v);
    endtask

    initial begin
        logic [7:0]  b;
        logic [31:0] exp_adr;
        logic        blk;

        for (int i = 0; i < 64; i++) begin
            b = 8'(i);
            ram[i] = {b, b, b, b};
        end
        ram[0] = 32'hE04F000F;

        // Idle / DMA-alone / contention / lock / non-owner write / DMA write sequence
        add(0,0,0,0,0, 1,0,0,0, 0,32'h0);
        add(0,0,1,0,0, 1,0,0,0, 0,32'h0);
        add(0,0,1,0,0, 0,1,0,0, 1,32'hE04F000F);
        add(1,0,0,0,0, 0,1,1,0, 0,32'h0);
        add(0,0,0,0,0, 1,0,0,0, 0,32'h0);
        for (int k = 0; k < 20; k++) begin
            blk = ((k / 5) % 2) == 1;
            add(1,0,1,0,0, !blk,blk,blk,0, 0,32'h0);
        end
        add(0,0,1,0,1, 1,0,0,0, 0,32'h0);
        for (int k = 0; k < 12; k++) add(1,0,1,0,1, 0,1,1,0, 0,32'h0);
        add(1,0,1,0,0, 0,1,1,0, 0,32'h0);
        add(1,0,1,0,0, 1,0,0,0, 0,32'h0);
        add(0,0,1,0,0, 1,0,0,0, 0,32'h0);
        add(1,1,1,0,0, 0,1,1,0, 0,32'h0);
        add(0,0,0,0,0, 0,1,0,0, 0,32'h0);
        add(0,0,1,1,0, 1,0,0,0, 0,32'h0);
        add(0,0,1,1,0, 0,1,0,1, 0,32'h0);
        add(1,1,0,0,0, 0,1,1,0, 0,32'h0);
        add(1,0,0,0,0, 1,0,0,0, 1,32'h11111111);

        // Reset with a CPU write pending
        reset    = 1'b0;
        cpu_req  = 1'b1; cpu_we = 1'b1; cpu_adr = 32'h40; cpu_wd = 32'hDEADBEEF;
        dma_req  = 1'b0; dma_we = 1'b0; dma_adr = 32'h0;  dma_wd = 32'h0;
        dma_lock = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset cpu_gnt",   32'(cpu_gnt),   32'd1);
        check("reset dma_gnt",   32'(dma_gnt),   32'd0);
        check("reset mem_we",    32'(mem_we),    32'd0);
        check("reset cpu_stall", 32'(cpu_stall), 32'd0);
        reset = 1'b1;
        #1;
        check("cpu write mem_we", 32'(mem_we), 32'd1);
        @(posedge clk);
        #1;
        check("cpu write ram[0x10]", ram[16], 32'hDEADBEEF);

        cpu_adr = 32'h44; cpu_wd = 32'hC0C0C0C0;
        dma_adr = 32'h0;  dma_wd = 32'hD0D0D0D0;
        for (int i = 0; i < tbl.size(); i++) begin
            cpu_req = tbl[i].creq; cpu_we = tbl[i].cwe;
            dma_req = tbl[i].dreq; dma_we = tbl[i].dwe; dma_lock = tbl[i].lock;
            @(negedge clk);
            exp_adr = tbl[i].cgnt ? cpu_adr : dma_adr;
            check($sformatf("v%0d cpu_gnt", i),   32'(cpu_gnt),   32'(tbl[i].cgnt));
            check($sformatf("v%0d dma_gnt", i),   32'(dma_gnt),   32'(tbl[i].dgnt));
            check($sformatf("v%0d cpu_stall", i), 32'(cpu_stall), 32'(tbl[i].stall));
            check($sformatf("v%0d mem_we", i),    32'(mem_we),    32'(tbl[i].mwe));
            check($sformatf("v%0d mem_adr", i),   mem_adr,        exp_adr);
            if (tbl[i].chk_rd) begin
                check($sformatf("v%0d cpu_rd", i), cpu_rd, tbl[i].rd);
                check($sformatf("v%0d dma_rd", i), dma_rd, tbl[i].rd);
            end
            @(posedge clk);
            #1;
        end
        check("non-owner write ram[0x11]", ram[17], 32'h11111111);
        check("dma write ram[0x0]",        ram[0],  32'hD0D0D0D0);

        // Reset in the middle of a DMA write
        cpu_req = 1'b0; cpu_we = 1'b0; dma_lock = 1'b0;
        dma_req = 1'b1; dma_we = 1'b1; dma_adr = 32'h8; dma_wd = 32'hABCD1234;
        @(negedge clk);
        check("midrst pre cpu_gnt", 32'(cpu_gnt), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst dma_gnt before", 32'(dma_gnt), 32'd1);
        check("midrst mem_we before",  32'(mem_we),  32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("midrst dma_gnt async", 32'(dma_gnt), 32'd0);
        check("midrst mem_we async",  32'(mem_we),  32'd0);
        check("midrst cpu_gnt async", 32'(cpu_gnt), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst ram[2] untouched", ram[2], 32'h02020202);
        check("midrst release cpu_gnt",  32'(cpu_gnt), 32'd1);
        check("midrst release dma_gnt",  32'(dma_gnt), 32'd0);
        dma_req = 1'b0; dma_we = 1'b0;
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
